// File: rtl/sys_arr_bmm_dbuf.sv
// Weight-stationary systolic block-matrix multiplier (y = W*x) with an
// active/shadow weight bank pair, output shift, ReLU and saturation.
module sys_arr_bmm_dbuf #(
    parameter int N_IN      = 4,
    parameter int N_OUT     = 4,
    parameter int DATA_WDT  = 8,
    parameter int OUT_WDT   = 16,
    parameter int TYPE_WDT  = 2,
    parameter int SHIFT_WDT = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic                         in_val,
    input  logic                         in_last,
    input  logic [TYPE_WDT-1:0]          in_type,
    input  logic [N_IN*DATA_WDT-1:0]     in_data,
    input  logic                         wgt_val,
    input  logic [$clog2(N_OUT)-1:0]     wgt_row,
    input  logic [N_IN*DATA_WDT-1:0]     wgt_data,
    input  logic                         wgt_swap,
    input  logic                         cfg_signed,
    input  logic                         cfg_relu,
    input  logic [SHIFT_WDT-1:0]         cfg_shift,
    output logic                         out_val,
    output logic                         out_last,
    output logic [TYPE_WDT-1:0]          out_type,
    output logic [N_OUT*OUT_WDT-1:0]     out_data,
    output logic                         wgt_bank,
    output logic                         wgt_shadow_full,
    output logic                         wgt_swap_err
);

    localparam int SUM_WDT  = 2*DATA_WDT + $clog2(N_IN) + 1;
    localparam int PROD_WDT = 2*DATA_WDT + 2;
    localparam int NSK      = N_IN*(N_IN-1)/2;

    localparam logic signed [SUM_WDT-1:0] SAT_SMAX_C = SUM_WDT'((64'sd1 <<< (OUT_WDT-1)) - 64'sd1);
    localparam logic signed [SUM_WDT-1:0] SAT_SMIN_C = SUM_WDT'(-(64'sd1 <<< (OUT_WDT-1)));
    localparam logic signed [SUM_WDT-1:0] SAT_UMAX_C = SUM_WDT'((64'sd1 <<< OUT_WDT) - 64'sd1);

    // Skew lines are packed triangularly: element k owns k slots starting here.
    function automatic int skew_base(input int k);
        return k*(k-1)/2;
    endfunction

    function automatic logic signed [SUM_WDT-1:0] mac_term(
        input logic [DATA_WDT-1:0] a,
        input logic [DATA_WDT-1:0] b,
        input logic                sgn
    );
        logic signed [DATA_WDT:0]   ae;
        logic signed [DATA_WDT:0]   be;
        logic signed [PROD_WDT-1:0] p;
        ae = sgn ? $signed({a[DATA_WDT-1], a}) : $signed({1'b0, a});
        be = sgn ? $signed({b[DATA_WDT-1], b}) : $signed({1'b0, b});
        p  = PROD_WDT'(ae) * PROD_WDT'(be);
        return SUM_WDT'(p);
    endfunction

    function automatic logic [OUT_WDT-1:0] shape_out(
        input logic signed [SUM_WDT-1:0] v,
        input logic                      sgn,
        input logic                      relu,
        input logic [SHIFT_WDT-1:0]      sh
    );
        logic signed [SUM_WDT-1:0] s;
        logic [OUT_WDT-1:0]        r;
        if (sgn) s = v >>> sh;
        else     s = v >> sh;
        if (sgn && relu && s[SUM_WDT-1]) s = '0;
        else                             s = s;
        if (sgn) begin
            if (s > SAT_SMAX_C)      r = SAT_SMAX_C[OUT_WDT-1:0];
            else if (s < SAT_SMIN_C) r = SAT_SMIN_C[OUT_WDT-1:0];
            else                     r = s[OUT_WDT-1:0];
        end else begin
            if (s[SUM_WDT-1])        r = '0;
            else if (s > SAT_UMAX_C) r = '1;
            else                     r = s[OUT_WDT-1:0];
        end
        return r;
    endfunction

    logic [DATA_WDT-1:0]        bank_r [2][N_OUT][N_IN];
    logic                       act_bank_r;
    logic [N_OUT-1:0]           mask_r;
    logic                       full_r;
    logic                       swap_err_r;
    logic                       swap_ok_s;
    logic                       wr_bank_s;
    logic [N_OUT-1:0]           row_hit_s;
    logic [N_OUT-1:0]           mask_s;

    logic [DATA_WDT-1:0]        xsk_r [NSK];
    logic [DATA_WDT-1:0]        wsk_r [NSK][N_OUT];
    logic signed [SUM_WDT-1:0]  psum_r [N_IN][N_OUT];
    logic signed [SUM_WDT-1:0]  term_s [N_IN][N_OUT];
    logic [N_IN-1:0]            vld_r;
    logic [N_IN-1:0]            lst_r;
    logic [TYPE_WDT-1:0]        typ_r [N_IN];

    logic [N_OUT*OUT_WDT-1:0]   shaped_s;
    logic                       out_val_r;
    logic                       out_last_r;
    logic [TYPE_WDT-1:0]        out_type_r;
    logic [N_OUT*OUT_WDT-1:0]   out_data_r;

    // Shadow write target and mask update; an accepted swap redirects the write to the outgoing active bank.
    always_comb begin
        swap_ok_s = 1'b0;
        wr_bank_s = 1'b0;
        row_hit_s = '0;
        mask_s    = '0;
        swap_ok_s = wgt_swap & full_r;
        if (swap_ok_s) wr_bank_s = act_bank_r;
        else           wr_bank_s = ~act_bank_r;
        for (int o = 0; o < N_OUT; o++) begin
            row_hit_s[o] = wgt_val && (int'(wgt_row) == o);
        end
        if (swap_ok_s) mask_s = row_hit_s;
        else           mask_s = mask_r | row_hit_s;
    end

    // Weight banks, bank select, row mask and swap status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_bank_r <= 1'b0;
            mask_r     <= '0;
            full_r     <= 1'b0;
            swap_err_r <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int o = 0; o < N_OUT; o++)
                    for (int k = 0; k < N_IN; k++)
                        bank_r[b][o][k] <= '0;
        end else if (clk_en) begin
            if (swap_ok_s) act_bank_r <= ~act_bank_r;
            mask_r     <= mask_s;
            full_r     <= &mask_s;
            swap_err_r <= wgt_swap & ~full_r;
            for (int o = 0; o < N_OUT; o++) begin
                if (row_hit_s[o]) begin
                    for (int k = 0; k < N_IN; k++)
                        bank_r[wr_bank_s][o][k] <= wgt_data[k*DATA_WDT +: DATA_WDT];
                end
            end
        end
    end

    // Per-stage products; later stages use weights snapshotted at acceptance so a post-swap rewrite cannot corrupt them.
    always_comb begin
        term_s = '{default: '0};
        for (int o = 0; o < N_OUT; o++)
            term_s[0][o] = mac_term(in_data[DATA_WDT-1:0], bank_r[act_bank_r][o][0], cfg_signed);
        for (int k = 1; k < N_IN; k++)
            for (int o = 0; o < N_OUT; o++)
                term_s[k][o] = mac_term(xsk_r[skew_base(k)+k-1], wsk_r[skew_base(k)+k-1][o], cfg_signed);
    end

    // Systolic pipeline: input/weight skew lines, partial sums and sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            lst_r <= '0;
            for (int s = 0; s < N_IN; s++) begin
                typ_r[s] <= '0;
                for (int o = 0; o < N_OUT; o++) psum_r[s][o] <= '0;
            end
            for (int i = 0; i < NSK; i++) begin
                xsk_r[i] <= '0;
                for (int o = 0; o < N_OUT; o++) wsk_r[i][o] <= '0;
            end
        end else if (clk_en) begin
            vld_r    <= {vld_r[N_IN-2:0], in_val};
            lst_r    <= {lst_r[N_IN-2:0], in_last};
            typ_r[0] <= in_type;
            for (int s = 1; s < N_IN; s++) typ_r[s] <= typ_r[s-1];
            for (int k = 1; k < N_IN; k++) begin
                xsk_r[skew_base(k)] <= in_data[k*DATA_WDT +: DATA_WDT];
                for (int o = 0; o < N_OUT; o++)
                    wsk_r[skew_base(k)][o] <= bank_r[act_bank_r][o][k];
                for (int j = 1; j < k; j++) begin
                    xsk_r[skew_base(k)+j] <= xsk_r[skew_base(k)+j-1];
                    for (int o = 0; o < N_OUT; o++)
                        wsk_r[skew_base(k)+j][o] <= wsk_r[skew_base(k)+j-1][o];
                end
            end
            for (int o = 0; o < N_OUT; o++) begin
                psum_r[0][o] <= term_s[0][o];
                for (int s = 1; s < N_IN; s++)
                    psum_r[s][o] <= psum_r[s-1][o] + term_s[s][o];
            end
        end
    end

    // Shift / ReLU / saturate each finished sum.
    always_comb begin
        shaped_s = '0;
        for (int o = 0; o < N_OUT; o++)
            shaped_s[o*OUT_WDT +: OUT_WDT] = shape_out(psum_r[N_IN-1][o], cfg_signed, cfg_relu, cfg_shift);
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_r  <= 1'b0;
            out_last_r <= 1'b0;
            out_type_r <= '0;
            out_data_r <= '0;
        end else if (clk_en) begin
            out_val_r  <= vld_r[N_IN-1];
            out_last_r <= lst_r[N_IN-1];
            out_type_r <= typ_r[N_IN-1];
            out_data_r <= shaped_s;
        end
    end

    assign out_val         = out_val_r;
    assign out_last        = out_last_r;
    assign out_type        = out_type_r;
    assign out_data        = out_data_r;
    assign wgt_bank        = act_bank_r;
    assign wgt_shadow_full = full_r;
    assign wgt_swap_err    = swap_err_r;

endmodule

// File: tb/tb_sys_arr_bmm_dbuf.sv
// Self-checking bench for sys_arr_bmm_dbuf: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_sys_arr_bmm_dbuf;
    localparam int N_IN = 4, N_OUT = 4, DW = 8, OW = 16, TW = 2, SW = 5;
    localparam int LAT = N_IN + 1;

    logic clk, rst_n, clk_en, in_val, in_last, wgt_val, wgt_swap;
    logic cfg_signed, cfg_relu;
    logic [TW-1:0] in_type, out_type;
    logic [N_IN*DW-1:0] in_data, wgt_data;
    logic [1:0] wgt_row;
    logic [SW-1:0] cfg_shift;
    logic out_val, out_last, wgt_bank, wgt_shadow_full, wgt_swap_err;
    logic [N_OUT*OW-1:0] out_data;

    sys_arr_bmm_dbuf #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_WDT(DW), .OUT_WDT(OW),
                       .TYPE_WDT(TW), .SHIFT_WDT(SW)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_val(in_val), .in_last(in_last),
        .in_type(in_type), .in_data(in_data), .wgt_val(wgt_val), .wgt_row(wgt_row),
        .wgt_data(wgt_data), .wgt_swap(wgt_swap), .cfg_signed(cfg_signed),
        .cfg_relu(cfg_relu), .cfg_shift(cfg_shift), .out_val(out_val), .out_last(out_last),
        .out_type(out_type), .out_data(out_data), .wgt_bank(wgt_bank),
        .wgt_shadow_full(wgt_shadow_full), .wgt_swap_err(wgt_swap_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit v; bit l; logic [1:0] t; logic [63:0] d; } rec_t;
    rec_t q[$];
    logic [7:0] wm [2][N_OUT][N_IN];
    bit act_m, full_m, err_m;
    bit [N_OUT-1:0] mask_m;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint elem(input logic [7:0] v);
        return cfg_signed ? longint'($signed(v)) : longint'(v);
    endfunction

    // y = W*x in plain arithmetic, then shift, ReLU, clamp.
    function automatic logic [63:0] model_y(input logic [31:0] x, input bit bank);
        logic [63:0] y;
        longint acc;
        y = '0;
        for (int o = 0; o < N_OUT; o++) begin
            acc = 0;
            for (int k = 0; k < N_IN; k++) acc += elem(x[k*8 +: 8]) * elem(wm[bank][o][k]);
            if (cfg_signed) begin
                acc = acc >>> cfg_shift;
                if (cfg_relu && acc < 0) acc = 0;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
            end else begin
                acc = acc >> cfg_shift;
                if (acc > 65535) acc = 65535;
                if (acc < 0) acc = 0;
            end
            y[o*16 +: 16] = 16'(acc);
        end
        return y;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int o = 0; o < N_OUT; o++)
                for (int k = 0; k < N_IN; k++) wm[b][o][k] = 8'h00;
        act_m = 1'b0; full_m = 1'b0; err_m = 1'b0; mask_m = '0;
        q.delete();
        repeat (LAT - 1) q.push_back('{1'b0, 1'b0, 2'b00, 64'h0});
    endtask

    // One clock: advance the model on enabled edges, then check every output.
    task automatic tick();
        rec_t r;
        bit swap_ok, tgt;
        if (clk_en) begin
            r.v = in_val; r.l = in_last; r.t = in_type;
            r.d = in_val ? model_y(in_data, act_m) : 64'h0;
            q.push_back(r);
            swap_ok = wgt_swap && full_m;
            err_m = wgt_swap && !full_m;
            if (wgt_val) begin
                tgt = swap_ok ? act_m : !act_m;
                for (int k = 0; k < N_IN; k++) wm[tgt][wgt_row][k] = wgt_data[k*8 +: 8];
            end
            if (swap_ok) begin
                act_m = !act_m;
                mask_m = '0;
            end
            if (wgt_val) mask_m[wgt_row] = 1'b1;
            full_m = &mask_m;
        end
        @(posedge clk);
        #1;
        while (q.size() > LAT) void'(q.pop_front());
        chk("out_val", 64'(out_val), 64'(q[0].v));
        if (q[0].v) begin
            chk("out_last", 64'(out_last), 64'(q[0].l));
            chk("out_type", 64'(out_type), 64'(q[0].t));
            chk("out_data", out_data, q[0].d);
        end
        chk("wgt_bank", 64'(wgt_bank), 64'(act_m));
        chk("shadow_full", 64'(wgt_shadow_full), 64'(full_m));
        chk("swap_err", 64'(wgt_swap_err), 64'(err_m));
    endtask

    task automatic idle();
        clk_en = 1'b1; in_val = 1'b0; in_last = 1'b0; in_type = '0;
        wgt_val = 1'b0; wgt_swap = 1'b0;
    endtask

    task automatic flush(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic wr_row(input logic [1:0] row, input logic [31:0] d);
        idle();
        wgt_val = 1'b1; wgt_row = row; wgt_data = d;
        tick();
        wgt_val = 1'b0;
    endtask

    task automatic vec(input logic [31:0] x, input bit last, input logic [1:0] t);
        in_val = 1'b1; in_data = x; in_last = last; in_type = t;
        tick();
        in_val = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_swap();
        wgt_swap = 1'b1;
        tick();
        wgt_swap = 1'b0;
    endtask

    task automatic load_uniform(input logic [31:0] d);
        for (int r = 0; r < N_OUT; r++) wr_row(2'(r), d);
        flush(1);
        do_swap();
        flush(1);
    endtask

    task automatic check_y(input string tag, input logic [31:0] x, input logic [63:0] y);
        vec(x, 1'b0, 2'b00);
        flush(LAT - 1);
        chk({tag, "_val"}, 64'(out_val), 64'd1);
        chk({tag, "_data"}, out_data, y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic old_bank;
        rst_n = 1'b0; idle(); in_data = '0; wgt_row = '0; wgt_data = '0;
        cfg_signed = 1'b0; cfg_relu = 1'b0; cfg_shift = '0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_out_val", 64'(out_val), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_bank", 64'(wgt_bank), 64'd0);
        chk("reset_full", 64'(wgt_shadow_full), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush(2);

        // Identity weights.
        for (int r = 0; r < N_OUT; r++) wr_row(2'(r), 32'h1 << (8*r));
        flush(1);
        do_swap();
        flush(1);
        check_y("identity", 32'h0403_0201, 64'h0004_0003_0002_0001);
        chk("identity_bank", 64'(wgt_bank), 64'd1);

        // Signed -1 rows, ReLU and shift.
        cfg_signed = 1'b1;
        load_uniform(32'hFFFF_FFFF);
        check_y("neg", 32'h7F7F_7F7F, {4{16'hFE04}});
        cfg_relu = 1'b1;
        check_y("relu", 32'h7F7F_7F7F, 64'h0);
        cfg_relu = 1'b0; cfg_shift = 5'd2;
        check_y("shift", 32'h7F7F_7F7F, {4{16'hFF81}});

        // Saturation, signed and unsigned.
        cfg_shift = 5'd0;
        load_uniform(32'h7F7F_7F7F);
        check_y("sat_s", 32'h7F7F_7F7F, {4{16'h7FFF}});
        cfg_signed = 1'b0;
        load_uniform(32'hFFFF_FFFF);
        check_y("sat_u", 32'hFFFF_FFFF, {4{16'hFFFF}});

        // Refused swap, then a swap straddled by back-to-back vectors.
        cfg_signed = 1'b1;
        for (int r = 0; r < 3; r++) wr_row(2'(r), $urandom);
        flush(1);
        old_bank = wgt_bank;
        do_swap();
        chk("swap_refused_err", 64'(wgt_swap_err), 64'd1);
        chk("swap_refused_bank", 64'(wgt_bank), 64'(old_bank));
        wr_row(2'd3, $urandom);
        flush(1);
        vec($urandom, 1'b0, 2'd1);
        wgt_swap = 1'b1; wgt_val = 1'b1; wgt_row = 2'd0; wgt_data = $urandom;
        vec($urandom, 1'b0, 2'd2);
        wgt_swap = 1'b0; wgt_row = 2'd1; wgt_data = $urandom;
        vec($urandom, 1'b0, 2'd3);
        flush(LAT + 1);
        chk("swap_bank", 64'(wgt_bank), 64'(!old_bank));

        // clk_en held low for three cycles behind the last vector of a block.
        vec($urandom, 1'b0, 2'd1);
        vec($urandom, 1'b1, 2'd2);
        cnt = 1;
        clk_en = 1'b0; in_val = 1'b1; wgt_val = 1'b1; wgt_swap = 1'b1; in_data = $urandom;
        repeat (3) begin tick(); cnt++; end
        idle();
        while (!(out_val && out_last) && cnt < 20) begin tick(); cnt++; end
        chk("en_latency", 64'(cnt), 64'd8);
        chk("en_type", 64'(out_type), 64'd2);
        flush(2);

        // Randomized traffic under several configurations.
        for (int ph = 0; ph < 4; ph++) begin
            cfg_signed = 1'($urandom); cfg_relu = 1'($urandom);
            cfg_shift = 5'($urandom_range(0, 12));
            for (int c = 0; c < 300; c++) begin
                clk_en   = ($urandom_range(0, 9) < 9);
                in_val   = ($urandom_range(0, 9) < 7);
                in_last  = 1'($urandom); in_type = 2'($urandom); in_data = $urandom;
                wgt_val  = ($urandom_range(0, 9) < 3);
                wgt_row  = 2'($urandom); wgt_data = $urandom;
                wgt_swap = ($urandom_range(0, 9) < 1);
                tick();
            end
            flush(LAT + 1);
        end

        // Asynchronous reset with vectors in flight.
        for (int c = 0; c < 3; c++) vec($urandom, 1'b0, 2'($urandom));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_val", 64'(out_val), 64'd0);
        chk("async_rst_out_data", out_data, 64'd0);
        chk("async_rst_bank", 64'(wgt_bank), 64'd0);
        chk("async_rst_full", 64'(wgt_shadow_full), 64'd0);
        model_reset();
        idle();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        flush(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
